// File: rtl/pll_hdmi_cfg_seq_pkg.sv
// rtl/pll_hdmi_cfg_seq_pkg.sv - register map, FSM states and buffer entry type for the PLL reconfig sequencer
package pll_hdmi_cfg_seq_pkg;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;

  // pll_cfg controller register map
  localparam logic [ADDR_W-1:0] REG_MODE   = 6'd0;
  localparam logic [ADDR_W-1:0] REG_STATUS = 6'd1;
  localparam logic [ADDR_W-1:0] REG_START  = 6'd2;
  localparam logic [ADDR_W-1:0] REG_N      = 6'd3;
  localparam logic [ADDR_W-1:0] REG_M      = 6'd4;
  localparam logic [ADDR_W-1:0] REG_C      = 6'd5;
  localparam logic [ADDR_W-1:0] REG_DPS    = 6'd6;
  localparam logic [ADDR_W-1:0] REG_K      = 6'd7;
  localparam logic [ADDR_W-1:0] REG_BW     = 6'd8;
  localparam logic [ADDR_W-1:0] REG_CP     = 6'd9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MODE,
    ST_WR,
    ST_START,
    ST_BUSY,
    ST_LOCK,
    ST_FIN
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/pll_hdmi_cfg_seq_if.sv
// rtl/pll_hdmi_cfg_seq_if.sv - Avalon-MM write path from the sequencer to the pll_cfg controller
interface pll_hdmi_cfg_seq_if;
  logic [5:0]  mgmt_address;
  logic        mgmt_write;
  logic [31:0] mgmt_writedata;
  logic        mgmt_waitrequest;

  modport master (
    output mgmt_address,
    output mgmt_write,
    output mgmt_writedata,
    input  mgmt_waitrequest
  );

  modport slave (
    input  mgmt_address,
    input  mgmt_write,
    input  mgmt_writedata,
    output mgmt_waitrequest
  );
endinterface

// File: rtl/pll_hdmi_cfg_seq_fifo.sv
// rtl/pll_hdmi_cfg_seq_fifo.sv - synchronous {addr,data} write buffer, DEPTH must be a power of two
module pll_hdmi_cfg_seq_fifo
  import pll_hdmi_cfg_seq_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  entry_t push_data,
  input  logic   pop,
  output logic   full,
  output logic   empty,
  output entry_t head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Storage array; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally at DEPTH; count tracks occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pll_hdmi_cfg_seq.sv
// rtl/pll_hdmi_cfg_seq.sv - replays buffered PLL register writes onto pll_cfg and waits for lock
module pll_hdmi_cfg_seq
  import pll_hdmi_cfg_seq_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int LOCK_STABLE  = 16,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [5:0]  ld_addr,
  input  logic [31:0] ld_data,
  input  logic        go,
  output logic        busy,
  output logic        done,
  output logic        err,
  pll_hdmi_cfg_seq_if.master mgmt,
  input  logic        pll_locked
);

  localparam logic [15:0] STABLE_C  = 16'(LOCK_STABLE);
  localparam logic [15:0] TIMEOUT_C = 16'(LOCK_TIMEOUT);

  state_t      state;
  logic        wr_q;
  logic [5:0]  addr_q;
  logic [31:0] data_q;
  logic        lock_meta;
  logic        locked_sync;
  logic [15:0] run_cnt;
  logic [15:0] lock_cnt;
  logic [15:0] run_nxt;
  logic [15:0] lock_nxt;
  entry_t      ld_entry;
  entry_t      head;
  logic        fifo_full;
  logic        fifo_empty;
  logic        push;
  logic        pop;

  // Loading is only open between sequences, and held off while reset is asserted
  assign ld_ready = !rst && !busy && !fifo_full;
  assign push     = ld_valid && ld_ready;
  assign ld_entry = {ld_addr, ld_data};
  // An entry leaves the buffer only when its bus write actually completes
  assign pop      = (state == ST_WR) && wr_q && !mgmt.mgmt_waitrequest;

  assign mgmt.mgmt_write     = wr_q;
  assign mgmt.mgmt_address   = addr_q;
  assign mgmt.mgmt_writedata = data_q;

  pll_hdmi_cfg_seq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (ld_entry),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head)
  );

  // Two-flop synchroniser for the asynchronous PLL lock indication
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_meta   <= 1'b0;
      locked_sync <= 1'b0;
    end else begin
      lock_meta   <= pll_locked;
      locked_sync <= lock_meta;
    end
  end

  // Next values of the saturating lock-run and elapsed-time counters
  always_comb begin
    run_nxt  = '0;
    if (locked_sync) run_nxt = (run_cnt == '1) ? run_cnt : run_cnt + 16'd1;
    lock_nxt = (lock_cnt == '1) ? lock_cnt : lock_cnt + 16'd1;
  end

  // Sequencer FSM with registered bus and status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      run_cnt  <= '0;
      lock_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (go) begin
            err <= 1'b0;
            if (fifo_empty) begin
              done <= 1'b1;
            end else begin
              state  <= ST_MODE;
              busy   <= 1'b1;
              wr_q   <= 1'b1;
              addr_q <= REG_MODE;
              data_q <= 32'd0;
            end
          end
        end
        ST_MODE: begin
          if (!mgmt.mgmt_waitrequest) begin
            wr_q  <= 1'b0;
            state <= ST_WR;
          end
        end
        ST_WR: begin
          // Each entry gets one cycle with write low to present the new buffer head
          if (!wr_q) begin
            wr_q <= 1'b1;
            if (fifo_empty) begin
              state  <= ST_START;
              addr_q <= REG_START;
              data_q <= 32'd1;
            end else begin
              addr_q <= head.addr;
              data_q <= head.data;
            end
          end else if (!mgmt.mgmt_waitrequest) begin
            wr_q <= 1'b0;
          end
        end
        ST_START: begin
          if (!mgmt.mgmt_waitrequest) begin
            wr_q  <= 1'b0;
            state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (!mgmt.mgmt_waitrequest) begin
            state    <= ST_LOCK;
            run_cnt  <= '0;
            lock_cnt <= '0;
          end
        end
        ST_LOCK: begin
          run_cnt  <= run_nxt;
          lock_cnt <= lock_nxt;
          // Stable lock takes priority over a timeout landing on the same cycle
          if (run_nxt >= STABLE_C) begin
            state <= ST_FIN;
            done  <= 1'b1;
            err   <= 1'b0;
          end else if (lock_nxt >= TIMEOUT_C) begin
            state <= ST_FIN;
            done  <= 1'b1;
            err   <= 1'b1;
          end
        end
        ST_FIN: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          wr_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
